universal_shift_register_n: RTL and testbench
=============================================

Name: universal_shift_register_n

Overview:
- Parametrised N-bit universal shift register. Adds rotate, arithmetic shift and a multi-cycle burst-shift engine on top of the basic hold / shift / load modes.
- Serves as the general-purpose register and serialiser building block in the datapath.
- Plain modes complete in one clock. Burst shift runs a small FSM with busy/done status.

Parameters:
- WIDTH, 8, register width in bits; must be >= 2.
- AMT_W, 4, width of burst shift-amount input; maximum burst length is 2^AMT_W - 1.

Ports:
- CLK  input  1  clock, rising edge.
- Clr  input  1  asynchronous, active-low reset.
- en  input  1  command enable; mode is ignored when low (hold).
- mode  input  3  operation select, see Behaviour.
- dir  input  1  burst direction: 0 = right (toward bit 0), 1 = left.
- amt  input  AMT_W  burst shift amount, sampled with the burst command.
- I_par  input  WIDTH  parallel load data.
- MSB_in  input  1  serial input entering bit WIDTH-1 on right shifts.
- LSB_in  input  1  serial input entering bit 0 on left shifts.
- A_par  output  WIDTH  register contents.
- MSB_out  output  1  A_par[WIDTH-1], combinational.
- LSB_out  output  1  A_par[0], combinational.
- busy  output  1  burst in progress.
- done  output  1  one-cycle burst-completion pulse.
- parity  output  1  see Optional Feature.

Behaviour:
- Reset (Clr low, asynchronous):
  - A_par = 0, busy = 0, done = 0.
  - FSM enters IDLE; internal count = 0.
  - Reset dominates every other input.
- FSM states: IDLE and BURST.
- In IDLE with en = 1, A_par updates on the next rising edge per mode:
  - 000 hold.
  - 001 shift right: A <= {MSB_in, A[W-1:1]}.
  - 010 shift left: A <= {A[W-2:0], LSB_in}.
  - 011 parallel load: A <= I_par.
  - 100 rotate right: A <= {A[0], A[W-1:1]}.
  - 101 rotate left: A <= {A[W-2:0], A[W-1]}.
  - 110 arithmetic shift right: A <= {A[W-1], A[W-1:1]}.
  - 111 burst command: latch amt and dir; A unchanged this edge.
    - If amt != 0: go to BURST, count <= amt, busy <= 1.
    - If amt == 0: stay in IDLE, done <= 1 for one cycle, no shift, busy stays 0.
- In IDLE with en = 0: hold.
- BURST:
  - Each rising edge shifts one position in the latched dir: right uses MSB_in, left uses LSB_in. Serial inputs are sampled live each cycle.
  - count decrements on each shift.
  - On the edge performing the final shift (count == 1): busy <= 0, done <= 1, return to IDLE. done is high in the same cycle A_par shows the final value.
  - Latency: amt cycles from the command edge to the done pulse.
  - en, mode, amt, dir and I_par are ignored while busy.
- done is high for exactly one cycle. A new command may be issued in the cycle done is high, since the FSM is already in IDLE.
- Clr asserted mid-burst aborts the burst: A_par = 0, busy = 0, and no done pulse.

Optional Feature:
- Macro: SHIFT_REG_PARITY_EN.
- Defined: parity = XOR-reduction of A_par (1 = odd number of ones), combinational, valid in every state including reset (0).
- Undefined: parity tied to 0; no parity logic is synthesised.
- The port list is identical in both builds.

Test Plan:
- Reset and load, W=8: pulse Clr low mid-cycle -> A_par=0x00, busy=0, done=0 immediately. Then mode=011, I_par=0xA5 -> A_par=0xA5 after one edge; with en=0 it holds 0xA5.
- Shifts and rotates from 0xA5:
  - rotate right -> 0xD2; then rotate left -> 0xA5.
  - load 0x0F, shift left with LSB_in=1 -> 0x1F.
  - shift right with MSB_in=0 -> 0x0F.
- Arithmetic shift: load 0x96, mode=110 -> 0xCB, then 0xE5. Load 0x40, mode=110 -> 0x20. MSB_out/LSB_out track A_par.
- Burst:
  - load 0x81; mode=111, dir=0, amt=3, MSB_in=0 -> busy high 3 cycles, A_par = 0x40, 0x20, 0x10.
  - done high one cycle with 0x10 and busy=0.
  - mode changes during busy have no effect.
  - amt=0 -> done pulse next cycle, A_par unchanged, busy never high.
- Reset mid-burst: start burst dir=1, amt=5 from 0x01; assert Clr after 2 shifts -> A_par=0x00, busy=0, no done pulse. Then a new load of 0x3C works normally.
- Parity (built with SHIFT_REG_PARITY_EN): A_par=0xA5 -> parity=0; A_par=0x07 -> parity=1. Built without the macro, parity stays 0 throughout.

Source files
------------

// File: rtl/universal_shift_register_n.sv
// Parametrised universal shift register: hold/shift/load/rotate/arithmetic modes plus a burst-shift FSM.
// Define SHIFT_REG_PARITY_EN to drive parity with the XOR-reduction of A_par; otherwise parity is tied to 0.
//
// state   | meaning
// S_IDLE  | single-cycle modes accepted when en is high
// S_BURST | shifting one position per clock until count reaches 0
module universal_shift_register_n #(
  parameter int WIDTH = 8,
  parameter int AMT_W = 4
) (
  input  logic             CLK,
  input  logic             Clr,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic             dir,
  input  logic [AMT_W-1:0] amt,
  input  logic [WIDTH-1:0] I_par,
  input  logic             MSB_in,
  input  logic             LSB_in,
  output logic [WIDTH-1:0] A_par,
  output logic             MSB_out,
  output logic             LSB_out,
  output logic             busy,
  output logic             done,
  output logic             parity
);

  typedef enum logic {S_IDLE, S_BURST} state_t;

  localparam logic [2:0] M_HOLD  = 3'b000;
  localparam logic [2:0] M_SHR   = 3'b001;
  localparam logic [2:0] M_SHL   = 3'b010;
  localparam logic [2:0] M_LOAD  = 3'b011;
  localparam logic [2:0] M_ROR   = 3'b100;
  localparam logic [2:0] M_ROL   = 3'b101;
  localparam logic [2:0] M_ASR   = 3'b110;
  localparam logic [2:0] M_BURST = 3'b111;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [AMT_W-1:0] count_q, count_d;
  logic             dir_q, dir_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    count_d = count_q;
    dir_d   = dir_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (en) begin
          case (mode)
            M_HOLD:  a_d = a_q;
            M_SHR:   a_d = {MSB_in, a_q[WIDTH-1:1]};
            M_SHL:   a_d = {a_q[WIDTH-2:0], LSB_in};
            M_LOAD:  a_d = I_par;
            M_ROR:   a_d = {a_q[0], a_q[WIDTH-1:1]};
            M_ROL:   a_d = {a_q[WIDTH-2:0], a_q[WIDTH-1]};
            M_ASR:   a_d = {a_q[WIDTH-1], a_q[WIDTH-1:1]};
            M_BURST: begin
              dir_d = dir;
              // A zero-length burst completes immediately without ever raising busy.
              if (amt != '0) begin
                state_d = S_BURST;
                count_d = amt;
                busy_d  = 1'b1;
              end else begin
                done_d = 1'b1;
              end
            end
            default: a_d = a_q;
          endcase
        end
      end
      S_BURST: begin
        a_d     = dir_q ? {a_q[WIDTH-2:0], LSB_in} : {MSB_in, a_q[WIDTH-1:1]};
        count_d = count_q - AMT_W'(1);
        if (count_q == AMT_W'(1)) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge Clr) begin
    if (!Clr) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      count_q <= '0;
      dir_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      count_q <= count_d;
      dir_q   <= dir_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign A_par   = a_q;
  assign MSB_out = a_q[WIDTH-1];
  assign LSB_out = a_q[0];
  assign busy    = busy_q;
  assign done    = done_q;

`ifdef SHIFT_REG_PARITY_EN
  assign parity = ^a_q;
`else
  assign parity = 1'b0;
`endif

endmodule

// File: tb/tb_universal_shift_register_n.sv
// Self-checking bench for universal_shift_register_n (WIDTH=8, AMT_W=4) against an arithmetic reference model.
module tb_universal_shift_register_n;
  localparam int W     = 8;
  localparam int AW    = 4;
  localparam int HALF  = 1 << (W - 1);
  localparam int FULL  = 1 << W;

  logic          CLK = 1'b0;
  logic          Clr = 1'b0;
  logic          en = 1'b0;
  logic [2:0]    mode = 3'd0;
  logic          dir = 1'b0;
  logic [AW-1:0] amt = '0;
  logic [W-1:0]  I_par = '0;
  logic          MSB_in = 1'b0;
  logic          LSB_in = 1'b0;
  logic [W-1:0]  A_par;
  logic          MSB_out, LSB_out, busy, done, parity;

  int errors = 0;
  int checks = 0;

  // Reference model: register value as an integer plus remaining burst shifts.
  int m_a = 0;
  int m_left = 0;
  int m_dir = 0;
  int m_done = 0;

  universal_shift_register_n #(.WIDTH(W), .AMT_W(AW)) dut (
    .CLK(CLK), .Clr(Clr), .en(en), .mode(mode), .dir(dir), .amt(amt),
    .I_par(I_par), .MSB_in(MSB_in), .LSB_in(LSB_in), .A_par(A_par),
    .MSB_out(MSB_out), .LSB_out(LSB_out), .busy(busy), .done(done), .parity(parity)
  );

  always #5 CLK = ~CLK;

  function automatic int popcount_odd(input int v);
    int c = 0;
    for (int i = 0; i < W; i++) c += (v >> i) & 1;
    return c % 2;
  endfunction

  function automatic logic [W+4:0] model_vec();
    int p;
`ifdef SHIFT_REG_PARITY_EN
    p = popcount_odd(m_a);
`else
    p = 0;
`endif
    return {W'(m_a), (m_a / HALF) != 0, (m_a % 2) != 0, m_left != 0, m_done != 0, p != 0};
  endfunction

  function automatic logic [W+4:0] dut_vec();
    return {A_par, MSB_out, LSB_out, busy, done, parity};
  endfunction

  task automatic model_reset();
    m_a = 0; m_left = 0; m_done = 0;
  endtask

  task automatic model_step();
    int v = m_a;
    m_done = 0;
    if (m_left != 0) begin
      if (m_dir != 0) v = (v * 2) % FULL + int'(LSB_in);
      else            v = v / 2 + int'(MSB_in) * HALF;
      m_left--;
      if (m_left == 0) m_done = 1;
    end else if (en) begin
      case (mode)
        3'd1: v = v / 2 + int'(MSB_in) * HALF;
        3'd2: v = (v * 2) % FULL + int'(LSB_in);
        3'd3: v = int'(I_par);
        3'd4: v = v / 2 + (v % 2) * HALF;
        3'd5: v = (v * 2) % FULL + v / HALF;
        3'd6: v = v / 2 + (v / HALF) * HALF;
        3'd7: begin
          if (amt == 0) m_done = 1;
          else begin m_left = int'(amt); m_dir = int'(dir); end
        end
        default: ;
      endcase
    end
    m_a = v;
  endtask

  task automatic tick();
    @(posedge CLK);
    model_step();
    #1;
  endtask

  task automatic op(input logic e, input logic [2:0] m, input logic [W-1:0] d);
    en = e; mode = m; I_par = d;
    tick();
  endtask

  task automatic test_reset();
    @(negedge CLK);
    Clr = 1'b0; model_reset();
    #1;
    checks++;
    if (dut_vec() !== {W'(0), 5'b0}) begin
      errors++; $display("FAIL reset: got %b required %b", dut_vec(), {W'(0), 5'b0});
    end
    @(negedge CLK); Clr = 1'b1;
    op(1, 3'd3, 8'hA5);
    checks++;
    if (A_par !== 8'hA5 || dut_vec() !== model_vec()) begin
      errors++; $display("FAIL load_a5: got %h required a5", A_par);
    end
    op(0, 3'd1, 8'h00);
    op(0, 3'd3, 8'hFF);
    checks++;
    if (A_par !== 8'hA5 || dut_vec() !== model_vec()) begin
      errors++; $display("FAIL hold_en0: got %h required a5", A_par);
    end
  endtask

  task automatic test_shifts();
    logic [W-1:0] want [4] = '{8'hD2, 8'hA5, 8'h1F, 8'h0F};
    logic [W-1:0] got [4];
    op(1, 3'd4, 8'h00); got[0] = A_par;
    op(1, 3'd5, 8'h00); got[1] = A_par;
    op(1, 3'd3, 8'h0F);
    LSB_in = 1'b1;
    op(1, 3'd2, 8'h00); got[2] = A_par;
    MSB_in = 1'b0; LSB_in = 1'b0;
    op(1, 3'd1, 8'h00); got[3] = A_par;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (got[i] !== want[i]) begin
        errors++; $display("FAIL shift_step%0d: got %h required %h", i, got[i], want[i]);
      end
    end
    checks++;
    if (dut_vec() !== model_vec()) begin
      errors++; $display("FAIL shift_model: got %b required %b", dut_vec(), model_vec());
    end
  endtask

  task automatic test_arith();
    logic [W-1:0] want [3] = '{8'hCB, 8'hE5, 8'h20};
    logic [W-1:0] got [3];
    logic [1:0]   edges [3];
    op(1, 3'd3, 8'h96);
    op(1, 3'd6, 8'h00); got[0] = A_par; edges[0] = {MSB_out, LSB_out};
    op(1, 3'd6, 8'h00); got[1] = A_par; edges[1] = {MSB_out, LSB_out};
    op(1, 3'd3, 8'h40);
    op(1, 3'd6, 8'h00); got[2] = A_par; edges[2] = {MSB_out, LSB_out};
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (got[i] !== want[i] || edges[i] !== {want[i][W-1], want[i][0]}) begin
        errors++; $display("FAIL asr%0d: got %h msb/lsb %b required %h", i, got[i], edges[i], want[i]);
      end
    end
  endtask

  task automatic test_burst();
    int busy_cycles = 0;
    int seen_done = 0;
    op(1, 3'd3, 8'h81);
    dir = 1'b0; amt = 4'd3; MSB_in = 1'b0;
    op(1, 3'd7, 8'h00);
    // Inputs that would change A if they were honoured while busy.
    en = 1'b1; mode = 3'd3; I_par = 8'hFF; amt = 4'd9; dir = 1'b1;
    for (int i = 0; i < 20; i++) begin
      checks++;
      if (dut_vec() !== model_vec()) begin
        errors++; $display("FAIL burst_cycle%0d: got %b required %b", i, dut_vec(), model_vec());
      end
      if (done) begin seen_done = 1; break; end
      if (busy) busy_cycles++;
      mode = 3'(i % 7);
      tick();
    end
    checks++;
    if (seen_done == 0 || busy_cycles != 3 || A_par !== 8'h10 || busy !== 1'b0) begin
      errors++; $display("FAIL burst_done: done_seen=%0d busy_cycles=%0d A=%h required done, 3 cycles, 10", seen_done, busy_cycles, A_par);
    end
    // Back-to-back: a load issued in the done cycle is accepted.
    op(1, 3'd3, 8'h55);
    checks++;
    if (A_par !== 8'h55 || done !== 1'b0 || dut_vec() !== model_vec()) begin
      errors++; $display("FAIL back_to_back: got %h done=%b required 55 done=0", A_par, done);
    end
  endtask

  task automatic test_burst_zero();
    logic b1, d1, d2;
    amt = 4'd0; dir = 1'b1;
    op(1, 3'd7, 8'h00);
    b1 = busy; d1 = done;
    checks++;
    if (d1 !== 1'b1 || b1 !== 1'b0 || A_par !== 8'h55) begin
      errors++; $display("FAIL burst_zero: done=%b busy=%b A=%h required 1 0 55", d1, b1, A_par);
    end
    op(0, 3'd0, 8'h00);
    d2 = done;
    checks++;
    if (d2 !== 1'b0 || busy !== 1'b0 || dut_vec() !== model_vec()) begin
      errors++; $display("FAIL burst_zero_pulse: done=%b busy=%b required 0 0", d2, busy);
    end
  endtask

  task automatic test_reset_mid_burst();
    int done_seen = 0;
    op(1, 3'd3, 8'h01);
    dir = 1'b1; amt = 4'd5; LSB_in = 1'b0;
    op(1, 3'd7, 8'h00);
    tick(); tick();
    checks++;
    if (A_par !== 8'h04 || busy !== 1'b1) begin
      errors++; $display("FAIL burst_left: got %h busy=%b required 04 1", A_par, busy);
    end
    #2; Clr = 1'b0; model_reset();
    #1;
    checks++;
    if (A_par !== 8'h00 || busy !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL abort: A=%h busy=%b done=%b required 00 0 0", A_par, busy, done);
    end
    #1; Clr = 1'b1;
    en = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (done) done_seen = 1;
    end
    checks++;
    if (done_seen != 0 || A_par !== 8'h00) begin
      errors++; $display("FAIL abort_no_done: done_seen=%0d A=%h required 0 00", done_seen, A_par);
    end
    op(1, 3'd3, 8'h3C);
    checks++;
    if (A_par !== 8'h3C || dut_vec() !== model_vec()) begin
      errors++; $display("FAIL reload: got %h required 3c", A_par);
    end
  endtask

  task automatic test_parity();
    logic p0, p1;
    op(1, 3'd3, 8'hA5); p0 = parity;
    op(1, 3'd3, 8'h07); p1 = parity;
    checks++;
`ifdef SHIFT_REG_PARITY_EN
    if (p0 !== 1'b0 || p1 !== 1'b1) begin
      errors++; $display("FAIL parity: got %b%b required 01", p0, p1);
    end
`else
    if (p0 !== 1'b0 || p1 !== 1'b0) begin
      errors++; $display("FAIL parity_off: got %b%b required 00", p0, p1);
    end
`endif
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      en = ($urandom_range(0, 7) != 0);
      mode = 3'($urandom_range(0, 7));
      dir = 1'($urandom);
      amt = AW'($urandom_range(0, 6));
      I_par = W'($urandom);
      MSB_in = 1'($urandom);
      LSB_in = 1'($urandom);
      if ($urandom_range(0, 49) == 0) begin
        #2; Clr = 1'b0; model_reset();
        #1; Clr = 1'b1;
      end
      tick();
      checks++;
      if (dut_vec() !== model_vec()) begin
        errors++; $display("FAIL random%0d: got %b required %b", i, dut_vec(), model_vec());
      end
    end
  endtask

  initial begin
    #3;
    Clr = 1'b1;
    test_reset();
    test_shifts();
    test_arith();
    test_burst();
    test_burst_zero();
    test_reset_mid_burst();
    test_parity();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
